interleaver: RTL and testbench

Block interleaver for the OFDM transmit chain, directly downstream of the puncturing stage. It accepts the punctured serial coded bit stream plus its map type and SIGNAL flag, and collects one OFDM symbol (Ncbps bits) into a ping-pong bit buffer. It then emits the symbol serially in the 802.11a two-step permuted order to the constellation mapper. The map type and SIGNAL flag are forwarded aligned with each symbol.

---
 rtl/interleaver_if.sv | 12 +
 rtl/interleaver.sv | 195 +++++++++++++++++++
 tb/tb_interleaver.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/interleaver_if.sv
// Serial coded-bit stream with valid/ready handshake plus per-symbol map type
// and SIGNAL flag sideband.
interface interleaver_if;
  logic       dat;
  logic       vld;
  logic       rdy;
  logic       sig_flag;
  logic [1:0] Map_Type;

  modport master (output dat, output vld, output sig_flag, output Map_Type, input rdy);
  modport slave  (input dat, input vld, input sig_flag, input Map_Type, output rdy);
endinterface

// File: rtl/interleaver.sv
// 802.11a block interleaver: ping-pong bit banks written in permuted order,
// read back sequentially through a two-stage registered output pipeline.
module interleaver #(
  parameter int unsigned BANK_DEPTH = 288
) (
  input  logic          clk,
  input  logic          rst_n,
  interleaver_if.slave  intlv_din,
  interleaver_if.master intlv_dout
);
  localparam int unsigned AW = $clog2(BANK_DEPTH);
  typedef logic [AW-1:0] addr_t;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_e;

  function automatic addr_t last_addr(input logic [1:0] mt);
    case (mt)
      2'b00:   return addr_t'(47);
      2'b01:   return addr_t'(95);
      2'b10:   return addr_t'(191);
      default: return addr_t'(287);
    endcase
  endfunction

  // Ncbps/16: distance in i between consecutive k within one row of 16
  function automatic addr_t row_step(input logic [1:0] mt);
    case (mt)
      2'b00:   return addr_t'(3);
      2'b01:   return addr_t'(6);
      2'b10:   return addr_t'(12);
      default: return addr_t'(18);
    endcase
  endfunction

  function automatic logic [1:0] span(input logic [1:0] mt);
    case (mt)
      2'b10:   return 2'd2;
      2'b11:   return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  bank_e                 st_q [2];
  bank_e                 st_d [2];
  logic [1:0]            map_q [2];
  logic                  sig_q [2];
  logic [BANK_DEPTH-1:0] mem_q [2];

  logic       wr_q, wr_d, rd_q, rd_d;
  addr_t      k_q, k_d, q_q, q_d, i_q, i_d, ra_q, ra_d;
  logic [3:0] r_q, r_d;
  logic [1:0] rm_q, rm_d, qm_q, qm_d;

  logic       s1_vld_q, s1_dat_q, s1_sig_q;
  logic [1:0] s1_map_q;
  logic       out_vld_q, out_dat_q, out_sig_q;
  logic [1:0] out_map_q;

  logic       din_rdy, wr_fire, wr_last;
  logic [1:0] wr_map, wr_s;
  addr_t      wr_addr;
  logic       out_en, rd_ok, rd_fire, rd_last;

  // Geometry comes from the live input only on k=0; afterwards the latched copy.
  assign wr_map  = (st_q[wr_q] == EMPTY) ? intlv_din.Map_Type : map_q[wr_q];
  assign wr_s    = span(wr_map);
  assign din_rdy = (st_q[wr_q] == EMPTY) || (st_q[wr_q] == FILLING);
  assign wr_fire = intlv_din.vld && din_rdy;
  assign wr_last = (k_q == last_addr(wr_map));

  // Ncbps and Ncbps/16 are multiples of s, so i mod s = q mod s and
  // j = i - (k mod s-step) with a +s wrap when (q mod s) < (r mod s).
  assign wr_addr = (qm_q >= rm_q) ? (i_q - addr_t'(rm_q))
                                  : (i_q + addr_t'(wr_s) - addr_t'(rm_q));

  assign out_en  = !out_vld_q || intlv_dout.rdy;
  assign rd_ok   = (st_q[rd_q] == FULL) || (st_q[rd_q] == DRAINING);
  assign rd_fire = out_en && rd_ok;
  assign rd_last = (ra_q == last_addr(map_q[rd_q]));

  always_comb begin
    st_d = st_q;
    wr_d = wr_q;
    rd_d = rd_q;
    k_d  = k_q;
    q_d  = q_q;
    i_d  = i_q;
    r_d  = r_q;
    rm_d = rm_q;
    qm_d = qm_q;
    ra_d = ra_q;
    if (wr_fire) begin
      if (wr_last) begin
        st_d[wr_q] = FULL;
        wr_d = ~wr_q;
        k_d  = '0;
        q_d  = '0;
        i_d  = '0;
        r_d  = '0;
        rm_d = '0;
        qm_d = '0;
      end else begin
        st_d[wr_q] = FILLING;
        k_d = k_q + addr_t'(1);
        if (r_q == 4'd15) begin
          r_d  = '0;
          rm_d = '0;
          q_d  = q_q + addr_t'(1);
          i_d  = q_q + addr_t'(1);
          qm_d = (qm_q == wr_s - 2'd1) ? 2'd0 : qm_q + 2'd1;
        end else begin
          r_d  = r_q + 4'd1;
          rm_d = (rm_q == wr_s - 2'd1) ? 2'd0 : rm_q + 2'd1;
          i_d  = i_q + row_step(wr_map);
        end
      end
    end
    if (rd_fire) begin
      if (rd_last) begin
        st_d[rd_q] = EMPTY;
        rd_d = ~rd_q;
        ra_d = '0;
      end else begin
        st_d[rd_q] = DRAINING;
        ra_d = ra_q + addr_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= '{EMPTY, EMPTY};
      map_q     <= '{2'b00, 2'b00};
      sig_q     <= '{1'b0, 1'b0};
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      k_q       <= '0;
      q_q       <= '0;
      i_q       <= '0;
      r_q       <= '0;
      rm_q      <= '0;
      qm_q      <= '0;
      ra_q      <= '0;
      s1_vld_q  <= 1'b0;
      s1_dat_q  <= 1'b0;
      s1_sig_q  <= 1'b0;
      s1_map_q  <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= 1'b0;
      out_sig_q <= 1'b0;
      out_map_q <= '0;
    end else begin
      st_q <= st_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      k_q  <= k_d;
      q_q  <= q_d;
      i_q  <= i_d;
      r_q  <= r_d;
      rm_q <= rm_d;
      qm_q <= qm_d;
      ra_q <= ra_d;
      if (wr_fire && (st_q[wr_q] == EMPTY)) begin
        map_q[wr_q] <= intlv_din.Map_Type;
        sig_q[wr_q] <= intlv_din.sig_flag;
      end
      // Both pipeline stages advance together; a stall freezes them intact.
      if (out_en) begin
        s1_vld_q <= rd_fire;
        if (rd_fire) begin
          s1_dat_q <= mem_q[rd_q][ra_q];
          s1_sig_q <= sig_q[rd_q];
          s1_map_q <= map_q[rd_q];
        end
        out_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          out_dat_q <= s1_dat_q;
          out_sig_q <= s1_sig_q;
          out_map_q <= s1_map_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_q][wr_addr] <= intlv_din.dat;
    end
  end

  assign intlv_din.rdy       = din_rdy;
  assign intlv_dout.dat      = out_dat_q;
  assign intlv_dout.vld      = out_vld_q;
  assign intlv_dout.sig_flag = out_sig_q;
  assign intlv_dout.Map_Type = out_map_q;
endmodule

// File: tb/tb_interleaver.sv
// Directed bench for the interleaver: single-one permutation vectors, back-to-back
// throughput, random backpressure ordering and mid-stream asynchronous reset.
module tb_interleaver;
  typedef logic [287:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  interleaver_if din_if ();
  interleaver_if dout_if ();

  interleaver #(.BANK_DEPTH(288)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .intlv_din  (din_if),
    .intlv_dout (dout_if)
  );

  int         checks = 0;
  int         failures = 0;
  bit         rand_rdy = 1'b0;
  logic [3:0] got_q [$];
  logic [3:0] exp_q [$];
  int         sym_len [$];
  int         done_syms = 0;
  int         out_in_sym = 0;

  task automatic check_eq(input string tag, input vec_t got, input vec_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ncb(input logic [1:0] mt);
    case (mt)
      2'b00:   return 48;
      2'b01:   return 96;
      2'b10:   return 192;
      default: return 288;
    endcase
  endfunction

  function automatic int spn(input logic [1:0] mt);
    case (mt)
      2'b10:   return 2;
      2'b11:   return 3;
      default: return 1;
    endcase
  endfunction

  function automatic vec_t rnd_bits();
    vec_t v;
    for (int b = 0; b < 288; b++) v[b] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic push_expected(input logic [1:0] mt, input logic sg, input vec_t bits);
    int   n = ncb(mt);
    int   s = spn(mt);
    vec_t o = '0;
    for (int k = 0; k < n; k++) begin
      int i = (n / 16) * (k % 16) + k / 16;
      int j = s * (i / s) + (i + n - (k % 16)) % s;
      o[j] = bits[k];
    end
    for (int j = 0; j < n; j++) exp_q.push_back({sg, mt, o[j]});
  endtask

  logic       r_now;
  logic       hold_pend = 1'b0;
  logic [3:0] hold_val = '0;

  // Output side: drive ready, record transfers, verify stability under stall.
  always @(negedge clk) begin
    r_now = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    if (hold_pend && rst_n)
      check_eq("hold_stable",
               vec_t'({dout_if.vld, dout_if.sig_flag, dout_if.Map_Type, dout_if.dat}),
               vec_t'({1'b1, hold_val}));
    dout_if.rdy = r_now;
    if (rst_n && dout_if.vld && r_now) begin
      got_q.push_back({dout_if.sig_flag, dout_if.Map_Type, dout_if.dat});
      out_in_sym++;
      if (done_syms < sym_len.size() && out_in_sym == sym_len[done_syms]) begin
        done_syms++;
        out_in_sym = 0;
      end
    end
    hold_pend = rst_n && dout_if.vld && !r_now;
    hold_val  = {dout_if.sig_flag, dout_if.Map_Type, dout_if.dat};
  end

  // Sends bits 0..stop_at-1 (all when stop_at<0); sideband inverted after k=0.
  task automatic send_sym(input logic [1:0] mt, input logic sg, input vec_t bits,
                          input int stop_at, output int stalls);
    int   n = ncb(mt);
    int   k = 0;
    int   budget = 0;
    logic acc;
    stalls = 0;
    while (k < n && k != stop_at) begin
      @(negedge clk);
      din_if.vld      = 1'b1;
      din_if.dat      = bits[k];
      din_if.Map_Type = (k == 0) ? mt : ~mt;
      din_if.sig_flag = (k == 0) ? sg : ~sg;
      acc = din_if.rdy;
      if (!acc) begin
        stalls++;
        check_eq("rdy_low_occ", vec_t'((sym_len.size() - done_syms) >= 2), vec_t'(1));
      end
      @(posedge clk);
      if (acc) k++;
      budget++;
      if (budget > 5000) begin
        check_eq("send_timeout", vec_t'(k), vec_t'(n));
        break;
      end
    end
    #1 din_if.vld = 1'b0;
    if (k == n) sym_len.push_back(n);
  endtask

  task automatic wait_items(input int n, input string tag);
    int b = 0;
    while (got_q.size() < n && b < 4000) begin
      @(negedge clk);
      #1;
      b++;
    end
    if (got_q.size() < n) check_eq({tag, "_timeout"}, vec_t'(got_q.size()), vec_t'(n));
  endtask

  task automatic run_single(input string tag, input logic [1:0] mt, input int kpos,
                            input int jpos, input bit meas);
    vec_t bits = '0;
    vec_t expv = '0;
    vec_t gotv = '0;
    int   n = ncb(mt);
    int   st;
    int   lat;
    bits[kpos] = 1'b1;
    expv[jpos] = 1'b1;
    got_q.delete();
    send_sym(mt, 1'b0, bits, -1, st);
    if (meas) begin
      lat = 0;
      do begin
        @(posedge clk);
        lat++;
        #1;
      end while (!dout_if.vld && lat < 10);
      check_eq({tag, "_latency"}, vec_t'(lat), vec_t'(2));
    end
    wait_items(n, tag);
    repeat (5) @(negedge clk);
    #1;
    check_eq({tag, "_count"}, vec_t'(got_q.size()), vec_t'(n));
    for (int j = 0; j < n && j < got_q.size(); j++) gotv[j] = got_q[j][0];
    check_eq(tag, gotv, expv);
    if (got_q.size() >= n)
      check_eq({tag, "_sig_map"}, vec_t'(got_q[n-1][3:1]), vec_t'({1'b0, mt}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t b0, b1, b2, b3;
    int   st0, st1, cyc, n_pre;

    din_if.vld      = 1'b0;
    din_if.dat      = 1'b0;
    din_if.sig_flag = 1'b0;
    din_if.Map_Type = 2'b00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_dout_vld", vec_t'({dout_if.dat, dout_if.vld}), vec_t'(0));
    check_eq("rst_sig_map", vec_t'({dout_if.sig_flag, dout_if.Map_Type}), vec_t'(0));
    check_eq("rst_din_rdy", vec_t'(din_if.rdy), vec_t'(1));
    rst_n = 1'b1;

    rand_rdy = 1'b0;
    run_single("bpsk_k1",  2'b00, 1,  3,  1'b1);
    run_single("bpsk_k16", 2'b00, 16, 1,  1'b0);
    run_single("qpsk_k17", 2'b01, 17, 7,  1'b0);
    run_single("qam16_k1", 2'b10, 1,  13, 1'b0);
    run_single("qam64_k1", 2'b11, 1,  20, 1'b0);

    // Back-to-back 64QAM with the mapper always ready: no stall, no bubble.
    got_q.delete();
    exp_q.delete();
    b0 = rnd_bits();
    b1 = rnd_bits();
    push_expected(2'b11, 1'b0, b0);
    push_expected(2'b11, 1'b0, b1);
    send_sym(2'b11, 1'b0, b0, -1, st0);
    send_sym(2'b11, 1'b0, b1, -1, st1);
    check_eq("b2b_in_stalls", vec_t'(st0 + st1), vec_t'(0));
    cyc = 0;
    while (got_q.size() < 576 && cyc < 2000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_eq("b2b_drain_cycles", vec_t'(cyc), vec_t'(290));
    for (int i = 0; i < 576 && i < got_q.size(); i++)
      check_eq("b2b_order", vec_t'(got_q[i]), vec_t'(exp_q[i]));

    // SIGNAL + 64QAM under random backpressure, then reset inside the next symbol.
    rand_rdy = 1'b1;
    got_q.delete();
    exp_q.delete();
    b0 = rnd_bits();
    b1 = rnd_bits();
    b2 = rnd_bits();
    push_expected(2'b00, 1'b1, b0);
    push_expected(2'b11, 1'b0, b1);
    send_sym(2'b00, 1'b1, b0, -1, st0);
    send_sym(2'b11, 1'b0, b1, -1, st1);
    send_sym(2'b11, 1'b0, b2, 100, st0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_dout", vec_t'(dout_if.dat), vec_t'(0));
    check_eq("midrst_vld", vec_t'(dout_if.vld), vec_t'(0));
    check_eq("midrst_sig", vec_t'(dout_if.sig_flag), vec_t'(0));
    check_eq("midrst_map", vec_t'(dout_if.Map_Type), vec_t'(0));
    check_eq("midrst_din_rdy", vec_t'(din_if.rdy), vec_t'(1));
    n_pre = got_q.size();
    check_eq("pre_rst_bound", vec_t'(n_pre <= 336), vec_t'(1));
    for (int i = 0; i < n_pre && i < 336; i++)
      check_eq("bp_order", vec_t'(got_q[i]), vec_t'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    sym_len.delete();
    done_syms  = 0;
    out_in_sym = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    b3 = rnd_bits();
    push_expected(2'b11, 1'b0, b3);
    send_sym(2'b11, 1'b0, b3, -1, st0);
    wait_items(288, "post_rst");
    repeat (10) @(negedge clk);
    #1;
    check_eq("post_rst_count", vec_t'(got_q.size()), vec_t'(288));
    for (int i = 0; i < 288 && i < got_q.size(); i++)
      check_eq("post_rst_order", vec_t'(got_q[i]), vec_t'(exp_q[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
